cpu_bus_dma: RTL and testbench

CPU_BUS_DMA -- requirements
Module: cpu_bus_dma

---
 rtl/cpu_bus_dma.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_bus_dma.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_dma.sv
// cpu_bus_dma: CPU bus address decoder with a sprite-style DMA engine.
//
// The CPU request (cpu_addr/cpu_dout/cpu_wr_en) is forwarded to a shared target bus
// (bus_addr/bus_wdata) and decoded into one of four write strobes:
// RAM $0000-$1FFF, PPU $2000-$3FFF, IO $4000-$4017, CART $4020-$FFFF.
// $4018-$401F and the DMA trigger register read as 8'h00 and drop writes.
// Targets answer reads one cycle late, so the decoded region is registered
// and used to pick which *_dout feeds cpu_din.
//
// A CPU write to DMA_REG latches the written byte as a source page and starts
// a burst: ALIGN (one cycle, plus one if the parity bit is odd), then
// DMA_LEN READ/WRITE pairs copying {page, idx} to DMA_DEST. The CPU is
// stalled (cpu_ready low) and its write enable ignored for the whole burst.
//
// Ports:
//   cpu_clock, reset_n           clock, asynchronous active-low reset
//   cpu_addr/cpu_dout/cpu_wr_en  CPU request;  cpu_din  read data to CPU
//   ext_ready / cpu_ready        external ready in; ready to CPU out
//   dma_active                   burst in progress
//   bus_addr/bus_wdata           shared target address / write data
//   *_wr_en / *_dout             per-region write strobes / read data
module cpu_bus_dma #(
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned DMA_LEN  = 256,
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] DMA_DEST = 16'h2004
) (
  input  logic        cpu_clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr_en,
  output logic [7:0]  cpu_din,
  input  logic        ext_ready,
  output logic        cpu_ready,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        ram_wr_en,
  output logic        ppu_wr_en,
  output logic        io_wr_en,
  output logic        cart_wr_en,
  input  logic [7:0]  ram_dout,
  input  logic [7:0]  ppu_dout,
  input  logic [7:0]  io_dout,
  input  logic [7:0]  cart_dout
);

  // The RAM offset is bus_addr[RAM_AW-1:0]; the RAM window is 8 KiB.
  if (RAM_AW == 0 || RAM_AW > 13) begin : g_ram_aw_check
    $error("RAM_AW must be in 1..13");
  end
  if (DMA_LEN == 0 || DMA_LEN > 256) begin : g_dma_len_check
    $error("DMA_LEN must be in 1..256");
  end

  localparam logic [8:0] LastIdx = 9'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StRead,
    StWrite
  } dma_state_e;

  typedef enum logic [2:0] {
    RgnRam,
    RgnPpu,
    RgnIo,
    RgnCart,
    RgnNone
  } region_e;

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic       parity_q, parity_d;
  region_e    region_q, region_d;

  logic [7:0] rd_data;
  logic       trigger;
  logic       last_idx;
  logic       bus_wr;
  logic       strobe_en;

  assign dma_active = (state_q != StIdle);
  assign cpu_ready  = ext_ready & ~dma_active;
  assign trigger    = ~dma_active & cpu_wr_en & (cpu_addr == DMA_REG);
  assign last_idx   = ({1'b0, idx_q} == LastIdx);

  // Read data of whichever region was addressed in the previous cycle.
  always_comb begin
    rd_data = 8'h00;
    unique case (region_q)
      RgnRam:  rd_data = ram_dout;
      RgnPpu:  rd_data = ppu_dout;
      RgnIo:   rd_data = io_dout;
      RgnCart: rd_data = cart_dout;
      default: rd_data = 8'h00;
    endcase
  end

  assign cpu_din = rd_data;

  // Bus mux: the CPU owns the bus only while idle.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_dout;
    unique case (state_q)
      StIdle: begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_dout;
      end
      StAlign, StRead: begin
        bus_addr  = {page_q, idx_q};
        bus_wdata = rd_data;
      end
      StWrite: begin
        bus_addr  = DMA_DEST;
        bus_wdata = rd_data;
      end
      default: begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_dout;
      end
    endcase
  end

  // Address decode. The trigger register is checked first so that it never
  // aliases into the IO strobe or read path.
  always_comb begin
    region_d = RgnCart;
    if (bus_addr == DMA_REG) begin
      region_d = RgnNone;
    end else if (bus_addr < 16'h2000) begin
      region_d = RgnRam;
    end else if (bus_addr < 16'h4000) begin
      region_d = RgnPpu;
    end else if (bus_addr < 16'h4018) begin
      region_d = RgnIo;
    end else if (bus_addr < 16'h4020) begin
      region_d = RgnNone;
    end
  end

  // CPU writes are ignored during a burst; DMA writes only in StWrite.
  // reset_n gates the strobes so they drop the instant reset asserts.
  assign bus_wr    = dma_active ? (state_q == StWrite) : cpu_wr_en;
  assign strobe_en = bus_wr & reset_n;

  assign ram_wr_en  = strobe_en & (region_d == RgnRam);
  assign ppu_wr_en  = strobe_en & (region_d == RgnPpu);
  assign io_wr_en   = strobe_en & (region_d == RgnIo);
  assign cart_wr_en = strobe_en & (region_d == RgnCart);

  assign parity_d = ~parity_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = StAlign;
        end
      end
      // An odd parity cycle is followed by an even one, so waiting for even
      // parity yields one or two ALIGN cycles.
      StAlign: begin
        if (!parity_q) begin
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StWrite;
      end
      StWrite: begin
        idx_d   = idx_q + 8'd1;
        state_d = last_idx ? StIdle : StRead;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      parity_q <= 1'b0;
      region_q <= RgnRam;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      parity_q <= parity_d;
      region_q <= region_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_dma.sv
module tb_cpu_bus_dma;

  localparam logic [15:0] DmaReg  = 16'h4014;
  localparam logic [15:0] DmaDest = 16'h2004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr_en;
  logic [7:0]  cpu_din;
  logic        ext_ready;
  logic        cpu_ready;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        ram_wr_en, ppu_wr_en, io_wr_en, cart_wr_en;
  logic [7:0]  ram_dout, ppu_dout, io_dout, cart_dout;

  // Second instance with a 4-byte burst; only its cart target is populated.
  logic [15:0] c4_addr;
  logic [7:0]  c4_dout;
  logic        c4_wr;
  logic [7:0]  c4_din;
  logic        ext4;
  logic        cpu_ready4;
  logic        dma_active4;
  logic [15:0] bus_addr4;
  logic [7:0]  bus_wdata4;
  logic        ram_wr4, ppu_wr4, io_wr4, cart_wr4;
  logic [7:0]  cart_dout4;
  logic [7:0]  zero8;
  assign zero8 = 8'h00;

  cpu_bus_dma dut (
    .cpu_clock (clk),        .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),   .cpu_dout  (cpu_dout),   .cpu_wr_en (cpu_wr_en),
    .cpu_din   (cpu_din),    .ext_ready (ext_ready),  .cpu_ready (cpu_ready),
    .dma_active(dma_active), .bus_addr  (bus_addr),   .bus_wdata (bus_wdata),
    .ram_wr_en (ram_wr_en),  .ppu_wr_en (ppu_wr_en),  .io_wr_en  (io_wr_en),
    .cart_wr_en(cart_wr_en), .ram_dout  (ram_dout),   .ppu_dout  (ppu_dout),
    .io_dout   (io_dout),    .cart_dout (cart_dout)
  );

  cpu_bus_dma #(.DMA_LEN(4)) dut4 (
    .cpu_clock (clk),         .reset_n   (reset_n),
    .cpu_addr  (c4_addr),     .cpu_dout  (c4_dout),    .cpu_wr_en (c4_wr),
    .cpu_din   (c4_din),      .ext_ready (ext4),       .cpu_ready (cpu_ready4),
    .dma_active(dma_active4), .bus_addr  (bus_addr4),  .bus_wdata (bus_wdata4),
    .ram_wr_en (ram_wr4),     .ppu_wr_en (ppu_wr4),    .io_wr_en  (io_wr4),
    .cart_wr_en(cart_wr4),    .ram_dout  (zero8),      .ppu_dout  (zero8),
    .io_dout   (zero8),       .cart_dout (cart_dout4)
  );

  // ---------------- target memories (environment) ----------------
  logic [7:0] ram_mem [0:2047] = '{default: 8'h00};
  logic [7:0] ppu_mem [0:7]    = '{default: 8'h00};
  logic [7:0] io_mem  [0:31]   = '{default: 8'h00};

  function automatic logic [7:0] cart_rom(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    ram_dout   <= ram_mem[bus_addr[10:0]];
    ppu_dout   <= ppu_mem[bus_addr[2:0]];
    io_dout    <= io_mem[bus_addr[4:0]];
    cart_dout  <= cart_rom(bus_addr);
    cart_dout4 <= cart_rom(bus_addr4);
    if (ram_wr_en) ram_mem[bus_addr[10:0]] <= bus_wdata;
    if (ppu_wr_en) ppu_mem[bus_addr[2:0]]  <= bus_wdata;
    if (io_wr_en)  io_mem[bus_addr[4:0]]   <= bus_wdata;
  end

  // ---------------- reference model ----------------
  logic [7:0] model_ram [0:2047] = '{default: 8'h00};
  logic [7:0] model_ppu [0:7]    = '{default: 8'h00};
  logic [7:0] model_io  [0:31]   = '{default: 8'h00};

  // Region codes: 0 RAM, 1 PPU, 2 IO, 3 CART, 4 none (disabled or trigger).
  function automatic int rgn_of(input logic [15:0] a);
    if (a == DmaReg) return 4;
    if (a < 16'h2000) return 0;
    if (a < 16'h4000) return 1;
    if (a < 16'h4018) return 2;
    if (a < 16'h4020) return 4;
    return 3;
  endfunction

  function automatic logic [3:0] onehot(input logic [2:0] r);
    case (r)
      3'd0: return 4'b0001;
      3'd1: return 4'b0010;
      3'd2: return 4'b0100;
      3'd3: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    case (rgn_of(a))
      0: return model_ram[a[10:0]];
      1: return model_ppu[a[2:0]];
      2: return model_io[a[4:0]];
      3: return cart_rom(a);
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0]  rgn;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_ev_t;

  typedef struct packed {
    int         due;
    logic [7:0] data;
  } rd_ev_t;

  wr_ev_t exp_q[$];
  wr_ev_t exp4_q[$];
  rd_ev_t rd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int pcnt     = 0;
  int cyc;
  int wr_seen  = 0;

  always @(posedge clk) pcnt <= pcnt + 1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic wr_ev_t mk_ev(input int r, input logic [15:0] a, input logic [7:0] d);
    wr_ev_t e;
    e.rgn  = 3'(r);
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  logic [3:0] mon_str;
  wr_ev_t     mon_ev;
  rd_ev_t     mon_rd;

  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      mon_str = {cart_wr_en, io_wr_en, ppu_wr_en, ram_wr_en};
      if (mon_str != 4'b0000) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", {mon_str, bus_addr, bus_wdata}, 32'h0);
        end else begin
          mon_ev = exp_q.pop_front();
          check_eq("write", {mon_str, bus_addr, bus_wdata},
                   {onehot(mon_ev.rgn), mon_ev.addr, mon_ev.data});
        end
      end
      if (rd_q.size() != 0 && rd_q[0].due == pcnt) begin
        mon_rd = rd_q.pop_front();
        check_eq("read_data", {24'h0, cpu_din}, {24'h0, mon_rd.data});
      end
      mon_str = {cart_wr4, io_wr4, ppu_wr4, ram_wr4};
      if (mon_str != 4'b0000) begin
        if (exp4_q.size() == 0) begin
          check_eq("unexpected_write4", {mon_str, bus_addr4, bus_wdata4}, 32'h0);
        end else begin
          mon_ev = exp4_q.pop_front();
          check_eq("write4", {mon_str, bus_addr4, bus_wdata4},
                   {onehot(mon_ev.rgn), mon_ev.addr, mon_ev.data});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cpu_op(input bit wr, input logic [15:0] a, input logic [7:0] d);
    int     r;
    rd_ev_t e;
    @(posedge clk); #1;
    cpu_addr  = a;
    cpu_dout  = d;
    cpu_wr_en = wr;
    r = rgn_of(a);
    if (wr) begin
      if (r != 4) exp_q.push_back(mk_ev(r, a, d));
      case (r)
        0: model_ram[a[10:0]] = d;
        1: model_ppu[a[2:0]]  = d;
        2: model_io[a[4:0]]   = d;
        default: ;
      endcase
    end else begin
      e.due  = pcnt + 1;
      e.data = model_read(a);
      rd_q.push_back(e);
    end
  endtask

  task automatic cpu_idle();
    @(posedge clk); #1;
    cpu_wr_en = 1'b0;
  endtask

  task automatic random_ops(input int n);
    logic [15:0] a;
    bit          wr;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
        1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:       a = 16'($urandom_range(16'h4000, 16'h4017));
        3:       a = 16'($urandom_range(16'h4018, 16'h401F));
        default: a = 16'($urandom_range(16'h4020, 16'hFFFF));
      endcase
      wr = 1'($urandom_range(0, 1));
      if (a == DmaReg) wr = 1'b0;
      cpu_op(wr, a, 8'($urandom));
    end
    cpu_idle();
  endtask

  task automatic push_page2_burst();
    logic [15:0] src;
    for (int i = 0; i < 256; i++) begin
      src = 16'h0200 + 16'(i);
      exp_q.push_back(mk_ev(1, DmaDest, model_ram[src[10:0]]));
    end
  endtask

  task automatic run_dma(input bit want_odd, input bit poke);
    int stall;
    @(posedge clk); #1;
    cpu_wr_en = 1'b0;
    for (int k = 0; k < 4 && ((cyc + 1) % 2) != int'(want_odd); k++) begin
      @(posedge clk); #1;
    end
    cpu_addr  = DmaReg;
    cpu_dout  = 8'h02;
    cpu_wr_en = 1'b1;
    push_page2_burst();
    model_ppu[4] = model_ram[11'h2FF];
    @(posedge clk); #1;
    // A CPU write attempted during the burst must not reach the bus.
    cpu_addr  = 16'h0203;
    cpu_dout  = 8'hEE;
    cpu_wr_en = poke;
    stall = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (cpu_ready) break;
      stall++;
      if (stall == 100) cpu_wr_en = 1'b0;
    end
    cpu_wr_en = 1'b0;
    if (want_odd) check_eq("stall_odd", stall, 514);
    else          check_eq("stall_even", stall, 513);
    check_eq("burst_drained", exp_q.size(), 0);
  endtask

  task automatic reset_mid_dma();
    int base;
    logic [15:0] src;
    @(posedge clk); #1;
    cpu_addr  = DmaReg;
    cpu_dout  = 8'h02;
    cpu_wr_en = 1'b1;
    push_page2_burst();
    @(posedge clk); #1;
    cpu_wr_en = 1'b0;
    base = wr_seen;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (wr_seen - base >= 10) break;
    end
    check_eq("reached_10_writes", wr_seen - base, 10);
    check_eq("strobe_before_reset", {31'h0, ppu_wr_en}, 1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_dma_active", {31'h0, dma_active}, 0);
    check_eq("rst_async_strobes", {28'h0, cart_wr_en, io_wr_en, ppu_wr_en, ram_wr_en}, 0);
    check_eq("rst_async_cpu_ready", {31'h0, cpu_ready}, {31'h0, ext_ready});
    exp_q.delete();
    src = 16'h0209;
    model_ppu[4] = model_ram[src[10:0]];
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cpu_op(1'b1, 16'h0000, 8'h77);
    cpu_op(1'b0, 16'h0000, 8'h00);
    cpu_idle();
  endtask

  task automatic dma4_test();
    int act, bad_ready, odd;
    @(posedge clk); #1;
    c4_addr = DmaReg;
    c4_dout = 8'hFF;
    c4_wr   = 1'b1;
    odd     = (cyc + 1) % 2;
    for (int i = 0; i < 4; i++) exp4_q.push_back(mk_ev(1, DmaDest, cart_rom(16'hFF00 + 16'(i))));
    @(posedge clk); #1;
    c4_wr = 1'b0;
    act = 0;
    bad_ready = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!dma_active4) break;
      act++;
      if (cpu_ready4) bad_ready++;
      #1 ext4 = 1'($urandom_range(0, 1));
    end
    check_eq("dma4_active_cycles", act, 9 + odd);
    check_eq("dma4_ready_during_burst", bad_ready, 0);
    check_eq("dma4_drained", exp4_q.size(), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("dma4_ready_follows_ext", {31'h0, cpu_ready4}, {31'h0, ext4});
      #1 ext4 = ~ext4;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ext_ready = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_dout  = 8'h11;
    cpu_wr_en = 1'b1;
    c4_addr   = 16'h0000;
    c4_dout   = 8'h00;
    c4_wr     = 1'b1;
    ext4      = 1'b1;
    #3;
    check_eq("rst_dma_active", {31'h0, dma_active}, 0);
    check_eq("rst_strobes", {28'h0, cart_wr_en, io_wr_en, ppu_wr_en, ram_wr_en}, 0);
    check_eq("rst_strobes4", {28'h0, cart_wr4, io_wr4, ppu_wr4, ram_wr4}, 0);
    check_eq("rst_cpu_ready_low", {31'h0, cpu_ready}, {31'h0, ext_ready});
    ext_ready = 1'b1;
    #1;
    check_eq("rst_cpu_ready_high", {31'h0, cpu_ready}, 1);
    check_eq("rst_cpu_ready4", {31'h0, cpu_ready4}, 1);
    cpu_wr_en = 1'b0;
    c4_wr     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    cpu_op(1'b1, 16'h0805, 8'hA5);
    cpu_op(1'b0, 16'h0005, 8'h00);
    cpu_op(1'b1, 16'h3FFA, 8'h3C);
    cpu_op(1'b0, 16'h4019, 8'h00);
    cpu_op(1'b0, DmaReg, 8'h00);
    cpu_op(1'b0, 16'h3FF2, 8'h00);
    cpu_idle();

    random_ops(60);

    for (int i = 0; i < 256; i++) begin
      cpu_op(1'b1, 16'h0200 + 16'(i) + 16'(16'h0800 * $urandom_range(0, 3)), 8'($urandom));
    end
    cpu_idle();

    run_dma(1'b0, 1'b1);
    run_dma(1'b1, 1'b0);
    cpu_op(1'b0, 16'h2004, 8'h00);
    cpu_op(1'b0, 16'h0203, 8'h00);
    cpu_idle();

    reset_mid_dma();
    dma4_test();

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_write_queue", exp_q.size(), 0);
    check_eq("final_read_queue", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
